ifu_fetch: RTL and testbench

Multi-cycle instruction fetch unit for the single-issue core. Owns the PC, issues one request at a time to instruction memory over a valid/ready bus, and presents the fetched word plus its PC to the decode stage with a valid/ready handshake. Sits directly upstream of `idu` and replaces the combinational instruction lookup. It advances only when the backend returns the next PC, so the core stays non-speculative.

---
 rtl/liang_pkg.sv | 26 ++
 rtl/ifu_fetch.sv | 96 +++++++++
 tb/tb_ifu_fetch.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/liang_pkg.sv
// ============================================================================
//  Module   : liang_pkg
//  Purpose  : Shared core types and constants for the single-issue core.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package liang_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] pc_t;
    typedef logic [31:0]     inst_t;

    localparam pc_t RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_NPC  = 2'd3
    } fetch_state_e;

endpackage : liang_pkg

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
//  Module   : ifu_fetch
//  Purpose  : Non-speculative multi-cycle instruction fetch; one imem request
//             in flight, PC advanced only by the backend's next-PC.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch
    import liang_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,

    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            imem_rsp_err_i,

    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            fault_o,

    input  logic            npc_valid_i,
    input  logic [XLEN-1:0] npc_i
);

    fetch_state_e state_q, state_d;
    pc_t          pc_q,    pc_d;
    inst_t        inst_q,  inst_d;
    logic         fault_q, fault_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        unique case (state_q)
            S_REQ: begin
                if (imem_req_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid_i) begin
                    inst_d  = imem_rsp_err_i ? '0 : imem_rsp_data_i;
                    fault_d = imem_rsp_err_i;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (inst_ready_i) state_d = S_NPC;
            end
            S_NPC: begin
                if (npc_valid_i) begin
                    pc_d = npc_i;
                    // A misaligned target never reaches memory; it is reported as a faulting instruction.
                    if (npc_i[1:0] == 2'b00) begin
                        state_d = S_REQ;
                    end else begin
                        inst_d  = '0;
                        fault_d = 1'b1;
                        state_d = S_OUT;
                    end
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    assign imem_req_valid_o = (state_q == S_REQ);
    assign imem_req_addr_o  = pc_q;
    assign inst_valid_o     = (state_q == S_OUT);
    assign inst_o           = inst_q;
    assign pc_o             = pc_q;
    assign fault_o          = fault_q;

endmodule : ifu_fetch

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
//  Module   : tb_ifu_fetch
//  Purpose  : Directed self-checking bench for ifu_fetch.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, pc;
    logic        fault;
    logic        npc_valid;
    logic [31:0] npc;

    int vectors = 0;
    int miss    = 0;
    int acc_cnt = 0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .imem_rsp_err_i   (rsp_err),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .inst_o           (inst),
        .pc_o             (pc),
        .fault_o          (fault),
        .npc_valid_i      (npc_valid),
        .npc_i            (npc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Handshake stability monitors and accepted-request counter.
    logic        prev_hold_req, prev_hold_inst;
    logic [31:0] prev_addr, prev_inst, prev_pc;
    logic        prev_fault;

    always @(posedge clk) begin
        if (!rst_n) begin
            prev_hold_req  <= 1'b0;
            prev_hold_inst <= 1'b0;
        end else begin
            if (prev_hold_req)  chk("req_addr_stable", req_addr, prev_addr);
            if (prev_hold_inst) begin
                chk("inst_stable",  inst, prev_inst);
                chk("pc_stable",    pc, prev_pc);
                chk("fault_stable", {31'd0, fault}, {31'd0, prev_fault});
            end
            if (req_valid && req_ready) acc_cnt++;
            prev_hold_req  <= req_valid && !req_ready;
            prev_hold_inst <= inst_valid && !inst_ready;
            prev_addr      <= req_addr;
            prev_inst      <= inst;
            prev_pc        <= pc;
            prev_fault     <= fault;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"},  {31'd0, req_valid},  32'd1);
        chk({tag, "_req_addr"},   req_addr,            32'h8000_0000);
        chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_inst"},       inst,                32'd0);
        chk({tag, "_fault"},      {31'd0, fault},      32'd0);
        chk({tag, "_pc"},         pc,                  32'h8000_0000);
    endtask

    initial begin
        int acc0;
        rst_n = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
        rsp_data = '0; inst_ready = 1'b0; npc_valid = 1'b0; npc = '0;
        step(); step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Best-case fetch from RESET_PC
        req_ready = 1'b1;
        step();
        chk("t1_wait_req_valid", {31'd0, req_valid}, 32'd0);
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0000_0513;
        step();
        chk("t1_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("t1_inst",  inst, 32'h0000_0513);
        chk("t1_pc",    pc,   32'h8000_0000);
        chk("t1_fault", {31'd0, fault}, 32'd0);
        rsp_valid = 1'b0; inst_ready = 1'b1;
        step();
        chk("t1_npc_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("t1_npc_req_valid",  {31'd0, req_valid},  32'd0);
        inst_ready = 1'b0; npc_valid = 1'b1; npc = 32'h8000_0004;
        step();
        chk("t1_next_req_valid", {31'd0, req_valid}, 32'd1);
        chk("t1_next_req_addr",  req_addr, 32'h8000_0004);
        npc_valid = 1'b0;

        // Memory back-pressure for three cycles
        acc0 = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_hold_req_valid", {31'd0, req_valid}, 32'd1);
            chk("t2_hold_req_addr",  req_addr, 32'h8000_0004);
        end
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk("t2_one_accept", acc_cnt - acc0, 32'd1);
        chk("t2_wait_req_valid", {31'd0, req_valid}, 32'd0);
        step();
        chk("t2_no_rsp_inst_valid", {31'd0, inst_valid}, 32'd0);
        rsp_valid = 1'b1; rsp_data = 32'h0000_0093;
        step();
        rsp_valid = 1'b0;
        chk("t2_inst", inst, 32'h0000_0093);
        chk("t2_pc",   pc,   32'h8000_0004);

        // Decode back-pressure for five cycles
        acc0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_inst_valid", {31'd0, inst_valid}, 32'd1);
            chk("t3_hold_inst", inst, 32'h0000_0093);
            chk("t3_hold_pc",   pc,   32'h8000_0004);
            chk("t3_hold_no_req", {31'd0, req_valid}, 32'd0);
        end
        chk("t3_no_accept", acc_cnt - acc0, 32'd0);
        inst_ready = 1'b1; npc_valid = 1'b1; npc = 32'h8000_0008;
        step();
        inst_ready = 1'b0;
        chk("t3_early_npc_ignored", {31'd0, req_valid}, 32'd0);
        step();
        chk("t3_req_valid", {31'd0, req_valid}, 32'd1);
        chk("t3_req_addr",  req_addr, 32'h8000_0008);
        npc = 32'h8000_0010;
        step();
        npc_valid = 1'b0;
        chk("t3_npc_once", req_addr, 32'h8000_0008);

        // Bus error response
        req_ready = 1'b1;
        step();
        req_ready = 1'b0; rsp_valid = 1'b1; rsp_err = 1'b1; rsp_data = 32'hDEAD_BEEF;
        step();
        rsp_valid = 1'b0; rsp_err = 1'b0;
        chk("t4_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("t4_fault", {31'd0, fault}, 32'd1);
        chk("t4_inst",  inst, 32'd0);
        chk("t4_pc",    pc,   32'h8000_0008);

        // Misaligned next PC faults without a memory request
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0; npc_valid = 1'b1; npc = 32'h8000_0102;
        acc0 = acc_cnt;
        step();
        npc_valid = 1'b0;
        chk("t5_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("t5_fault", {31'd0, fault}, 32'd1);
        chk("t5_pc",    pc,   32'h8000_0102);
        chk("t5_inst",  inst, 32'd0);
        chk("t5_no_req", {31'd0, req_valid}, 32'd0);
        chk("t5_no_accept", acc_cnt - acc0, 32'd0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0; npc_valid = 1'b1; npc = 32'h8000_000C;
        step();
        npc_valid = 1'b0;
        chk("t5_req_addr", req_addr, 32'h8000_000C);

        // Asynchronous reset while waiting for a response
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk("t6_in_wait", {31'd0, req_valid}, 32'd0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("t6_async");
        step();
        rst_n = 1'b1;
        step();
        chk("t6_fresh_req_valid", {31'd0, req_valid}, 32'd1);
        chk("t6_fresh_req_addr",  req_addr, 32'h8000_0000);
        acc0 = acc_cnt;
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk("t6_fresh_accept", acc_cnt - acc0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule : tb_ifu_fetch

`default_nettype wire
